// File: rtl/ysyx_23060180_pkg.sv
// Shared types and constants for the ysyx_23060180 load/store unit.
// Holds the FSM state encoding, access-size codes and the default memory latency.
package ysyx_23060180_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int unsigned MEM_LAT_DEF = 1;

    // Size code 3 is treated as a misaligned access so it shares the error path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060180_lsu_align.sv
// Combinational byte-lane logic: store data/mask placement and load lane
// selection with sign or zero extension.
module ysyx_23060180_lsu_align
    import ysyx_23060180_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_ldata
);

    logic [4:0]  w_shamt;
    logic [31:0] w_rshift;

    assign w_shamt  = {i_lane, 3'b000};
    assign w_rshift = i_rdata >> w_shamt;
    assign o_wdata  = i_wdata << w_shamt;

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        o_wmask = 4'b1111;
        o_ldata = i_rdata;
        case (i_size)
            SZ_B: begin
                o_wmask = 4'b0001 << i_lane;
                o_ldata = i_unsigned ? {24'd0, w_rshift[7:0]}
                                     : {{24{w_rshift[7]}}, w_rshift[7:0]};
            end
            SZ_H: begin
                o_wmask = 4'b0011 << i_lane;
                o_ldata = i_unsigned ? {16'd0, w_rshift[15:0]}
                                     : {{16{w_rshift[15]}}, w_rshift[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060180_lsu.sv
// Load/store unit: accepts one execute-stage request at a time, performs a
// single-beat memory access and returns a response held until accepted.
module ysyx_23060180_lsu
    import ysyx_23060180_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        mem_rd,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    lsu_state_e  r_state, w_next;
    logic        r_wr, r_unsigned, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [4:0]  r_rd;
    logic [2:0]  r_cnt;

    logic        w_accept, w_misaligned, w_cnt_done, w_issue_rd, w_issue_wr;
    logic [31:0] w_st_data, w_ld_data;
    logic [3:0]  w_st_mask;

    assign w_accept     = (r_state == ST_IDLE) && req_valid;
    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign w_cnt_done   = (r_cnt == 3'd0);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next = w_misaligned ? ST_RESP : ST_ISSUE;
            ST_ISSUE: w_next = r_wr ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (w_cnt_done) w_next = ST_RESP;
            ST_RESP:  if (resp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // The latency counter is preloaded at acceptance and only runs in WAIT.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            r_wr       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_wr       <= req_wr;
            r_unsigned <= req_unsigned;
            r_err      <= w_misaligned;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_rd       <= req_rd;
            r_cnt      <= LAT_M1;
        end else if (r_state == ST_WAIT) begin
            if (w_cnt_done) r_rdata <= w_ld_data;
            else            r_cnt   <= r_cnt - 3'd1;
        end
    end

    ysyx_23060180_lsu_align u_align (
        .i_lane     (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (mem_rdata),
        .o_wdata    (w_st_data),
        .o_wmask    (w_st_mask),
        .o_ldata    (w_ld_data)
    );

    assign w_issue_rd = (r_state == ST_ISSUE) && !r_wr;
    assign w_issue_wr = (r_state == ST_ISSUE) && r_wr;

    assign req_ready  = (r_state == ST_IDLE);
    assign mem_rd     = w_issue_rd;
    assign mem_raddr  = w_issue_rd ? {r_addr[31:2], 2'b00} : '0;
    assign mem_wr     = w_issue_wr;
    assign mem_waddr  = w_issue_wr ? {r_addr[31:2], 2'b00} : '0;
    assign mem_wdata  = w_issue_wr ? w_st_data : '0;
    assign mem_wmask  = w_issue_wr ? w_st_mask : '0;

    // Stores and errored requests carry no destination register.
    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_rdata;
    assign resp_rd    = (r_wr || r_err) ? 5'd0 : r_rd;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Directed testbench for ysyx_23060180_lsu: one instance with MEM_LAT=1 (_a)
// and one with MEM_LAT=3 (_b); inputs change and outputs are sampled on negedge.
module tb_ysyx_23060180_lsu;
    import ysyx_23060180_pkg::*;

    localparam logic [31:0] GARB = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rstn_in;
    logic        req_valid_a, req_valid_b, req_wr, req_unsigned, resp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata_a, mem_rdata_b;
    logic [4:0]  req_rd;

    logic        req_ready_a, resp_valid_a, resp_err_a, mem_rd_a, mem_wr_a;
    logic [31:0] resp_data_a, mem_raddr_a, mem_waddr_a, mem_wdata_a;
    logic [4:0]  resp_rd_a;
    logic [3:0]  mem_wmask_a;
    logic        req_ready_b, resp_valid_b, resp_err_b, mem_rd_b, mem_wr_b;
    logic [31:0] resp_data_b, mem_raddr_b, mem_waddr_b, mem_wdata_b;
    logic [4:0]  resp_rd_b;
    logic [3:0]  mem_wmask_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_23060180_lsu #(.MEM_LAT(1)) u_dut_a (
        .clk(clk), .rstn_in(rstn_in),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_data(resp_data_a),
        .resp_rd(resp_rd_a), .resp_err(resp_err_a),
        .mem_rd(mem_rd_a), .mem_raddr(mem_raddr_a), .mem_rdata(mem_rdata_a),
        .mem_wr(mem_wr_a), .mem_waddr(mem_waddr_a), .mem_wdata(mem_wdata_a),
        .mem_wmask(mem_wmask_a)
    );

    ysyx_23060180_lsu #(.MEM_LAT(3)) u_dut_b (
        .clk(clk), .rstn_in(rstn_in),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_data(resp_data_b),
        .resp_rd(resp_rd_b), .resp_err(resp_err_b),
        .mem_rd(mem_rd_b), .mem_raddr(mem_raddr_b), .mem_rdata(mem_rdata_b),
        .mem_wr(mem_wr_b), .mem_waddr(mem_waddr_b), .mem_wdata(mem_wdata_b),
        .mem_wmask(mem_wmask_b)
    );

    task automatic set_req(input logic wr, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd);
        req_wr = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
    endtask

    task automatic test_reset();
        rstn_in = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0; resp_ready = 1'b1;
        set_req(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 5'd0);
        mem_rdata_a = GARB; mem_rdata_b = GARB;
        #1;
        total++;
        if ({req_ready_a, resp_valid_a, mem_rd_a, mem_wr_a, resp_err_a} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctl_a got=%b exp=10000",
                            {req_ready_a, resp_valid_a, mem_rd_a, mem_wr_a, resp_err_a});
        end
        repeat (2) @(negedge clk);
        rstn_in = 1'b1;
        @(negedge clk);
        total++;
        if ({resp_data_a, resp_rd_a, mem_raddr_a, mem_waddr_a, mem_wdata_a, mem_wmask_a} !== '0) begin
            bad++; $display("FAIL reset_data_a got=%h/%h/%h/%h/%h/%h exp=all zero", resp_data_a,
                            resp_rd_a, mem_raddr_a, mem_waddr_a, mem_wdata_a, mem_wmask_a);
        end
        total++;
        if ({req_ready_b, resp_valid_b, mem_rd_b, mem_wr_b, resp_err_b, resp_data_b} !== {5'b10000, 32'h0}) begin
            bad++; $display("FAIL reset_ctl_b got=%b data=%h exp=10000 data=0",
                            {req_ready_b, resp_valid_b, mem_rd_b, mem_wr_b, resp_err_b}, resp_data_b);
        end
    endtask

    // Load on instance a; starts and ends at a negedge with the DUT idle.
    task automatic do_load_a(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                             input logic [4:0] rd, input logic [31:0] rdata,
                             input logic [31:0] exp, input string name);
        set_req(1'b0, size, uns, addr, 32'hFFFF_FFFF, rd);
        req_valid_a = 1'b1; resp_ready = 1'b1; mem_rdata_a = GARB;
        @(negedge clk);
        req_valid_a = 1'b0;
        total++;
        if ({mem_rd_a, mem_wr_a} !== 2'b10 || mem_raddr_a !== {addr[31:2], 2'b00}) begin
            bad++; $display("FAIL %s_issue rd/wr=%b raddr=%h exp=10 raddr=%h",
                            name, {mem_rd_a, mem_wr_a}, mem_raddr_a, {addr[31:2], 2'b00});
        end
        @(negedge clk);
        total++;
        if ({mem_rd_a, resp_valid_a} !== 2'b00) begin
            bad++; $display("FAIL %s_wait rd/valid=%b exp=00", name, {mem_rd_a, resp_valid_a});
        end
        mem_rdata_a = rdata;
        @(negedge clk);
        mem_rdata_a = GARB;
        total++;
        if (resp_valid_a !== 1'b1 || resp_data_a !== exp || resp_rd_a !== rd || resp_err_a !== 1'b0) begin
            bad++; $display("FAIL %s_resp valid=%b data=%h rd=%0d err=%b exp=1 %h %0d 0",
                            name, resp_valid_a, resp_data_a, resp_rd_a, resp_err_a, exp, rd);
        end
        @(negedge clk);
        total++;
        if ({req_ready_a, resp_valid_a} !== 2'b10) begin
            bad++; $display("FAIL %s_done ready/valid=%b exp=10", name, {req_ready_a, resp_valid_a});
        end
    endtask

    task automatic do_store_a(input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_mask, input string name);
        set_req(1'b1, size, 1'b0, addr, wdata, 5'd9);
        req_valid_a = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        total++;
        if ({mem_wr_a, mem_rd_a, resp_valid_a} !== 3'b100 || mem_waddr_a !== {addr[31:2], 2'b00} ||
            mem_wdata_a !== exp_wdata || mem_wmask_a !== exp_mask) begin
            bad++; $display("FAIL %s_issue wr/rd/v=%b waddr=%h wdata=%h mask=%b exp=100 %h %h %b",
                            name, {mem_wr_a, mem_rd_a, resp_valid_a}, mem_waddr_a, mem_wdata_a,
                            mem_wmask_a, {addr[31:2], 2'b00}, exp_wdata, exp_mask);
        end
        @(negedge clk);
        total++;
        if ({mem_wr_a, resp_valid_a, resp_err_a} !== 3'b010 || resp_rd_a !== 5'd0 || resp_data_a !== 32'd0) begin
            bad++; $display("FAIL %s_resp wr/v/err=%b rd=%0d data=%h exp=010 0 0",
                            name, {mem_wr_a, resp_valid_a, resp_err_a}, resp_rd_a, resp_data_a);
        end
        @(negedge clk);
        total++;
        if ({req_ready_a, resp_valid_a} !== 2'b10) begin
            bad++; $display("FAIL %s_done ready/valid=%b exp=10", name, {req_ready_a, resp_valid_a});
        end
    endtask

    task automatic do_err_a(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input string name);
        set_req(wr, size, 1'b0, addr, 32'hCAFE_BABE, 5'd13);
        req_valid_a = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        total++;
        if ({resp_valid_a, resp_err_a, mem_rd_a, mem_wr_a} !== 4'b1100 ||
            resp_rd_a !== 5'd0 || resp_data_a !== 32'd0) begin
            bad++; $display("FAIL %s v/err/rd/wr=%b rd=%0d data=%h exp=1100 0 0",
                            name, {resp_valid_a, resp_err_a, mem_rd_a, mem_wr_a}, resp_rd_a, resp_data_a);
        end
        @(negedge clk);
        total++;
        if ({req_ready_a, resp_valid_a, mem_rd_a, mem_wr_a} !== 4'b1000) begin
            bad++; $display("FAIL %s_done ready/v/rd/wr=%b exp=1000",
                            name, {req_ready_a, resp_valid_a, mem_rd_a, mem_wr_a});
        end
    endtask

    task automatic test_loads();
        do_load_a(32'h8000_0004, SZ_W, 1'b0, 5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");
        do_load_a(32'h8000_0003, SZ_B, 1'b0, 5'd6,  32'h80FF_7F01, 32'hFFFF_FF80, "lb");
        do_load_a(32'h8000_0003, SZ_B, 1'b1, 5'd7,  32'h80FF_7F01, 32'h0000_0080, "lbu");
        do_load_a(32'h8000_0000, SZ_B, 1'b0, 5'd8,  32'h80FF_7F01, 32'h0000_0001, "lb0");
        do_load_a(32'h8000_0002, SZ_H, 1'b0, 5'd9,  32'h80FF_7F01, 32'hFFFF_80FF, "lh");
        do_load_a(32'h8000_0002, SZ_H, 1'b1, 5'd10, 32'h80FF_7F01, 32'h0000_80FF, "lhu");
        do_load_a(32'h8000_0000, SZ_H, 1'b0, 5'd31, 32'h80FF_7F01, 32'h0000_7F01, "lh0");
    endtask

    task automatic test_stores();
        do_store_a(32'h8000_0002, SZ_H, 32'h1234_ABCD, 32'hABCD_0000, 4'b1100, "sh");
        do_store_a(32'h8000_0001, SZ_B, 32'h1122_3344, 32'h2233_4400, 4'b0010, "sb");
        do_store_a(32'h8000_0010, SZ_W, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, "sw");
    endtask

    task automatic test_misaligned();
        do_err_a(1'b0, SZ_W,  32'h8000_0002, "err_lw");
        do_err_a(1'b1, SZ_H,  32'h8000_0001, "err_sh");
        do_err_a(1'b0, 2'd3,  32'h8000_0000, "err_size3");
    endtask

    // MEM_LAT=3 with a stalled response, then a store held on req_* during the stall.
    task automatic test_stall_lat3();
        set_req(1'b0, SZ_W, 1'b0, 32'h8000_0008, 32'h0, 5'd7);
        req_valid_b = 1'b1; resp_ready = 1'b0; mem_rdata_b = GARB;
        @(negedge clk);
        req_valid_b = 1'b0;
        total++;
        if (mem_rd_b !== 1'b1 || mem_raddr_b !== 32'h8000_0008) begin
            bad++; $display("FAIL lat3_issue rd=%b raddr=%h exp=1 80000008", mem_rd_b, mem_raddr_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({mem_rd_b, resp_valid_b} !== 2'b00) begin
                bad++; $display("FAIL lat3_wait%0d rd/valid=%b exp=00", i, {mem_rd_b, resp_valid_b});
            end
        end
        mem_rdata_b = 32'h1357_9BDF;
        @(negedge clk);
        mem_rdata_b = GARB;
        set_req(1'b1, SZ_W, 1'b0, 32'h8000_0010, 32'h0BAD_F00D, 5'd3);
        req_valid_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (resp_valid_b !== 1'b1 || resp_data_b !== 32'h1357_9BDF || resp_rd_b !== 5'd7 ||
                resp_err_b !== 1'b0 || req_ready_b !== 1'b0 || mem_wr_b !== 1'b0) begin
                bad++; $display("FAIL lat3_stall%0d v=%b data=%h rd=%0d err=%b rdy=%b wr=%b exp=1 13579bdf 7 0 0 0",
                                i, resp_valid_b, resp_data_b, resp_rd_b, resp_err_b, req_ready_b, mem_wr_b);
            end
            if (i < 4) @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({req_ready_b, resp_valid_b, mem_wr_b} !== 3'b100) begin
            bad++; $display("FAIL lat3_after_hs ready/v/wr=%b exp=100", {req_ready_b, resp_valid_b, mem_wr_b});
        end
        @(negedge clk);
        req_valid_b = 1'b0;
        total++;
        if (mem_wr_b !== 1'b1 || mem_waddr_b !== 32'h8000_0010 || mem_wdata_b !== 32'h0BAD_F00D ||
            mem_wmask_b !== 4'b1111) begin
            bad++; $display("FAIL lat3_next_sw wr=%b waddr=%h wdata=%h mask=%b exp=1 80000010 0badf00d 1111",
                            mem_wr_b, mem_waddr_b, mem_wdata_b, mem_wmask_b);
        end
        @(negedge clk);
        total++;
        if ({resp_valid_b, mem_wr_b} !== 2'b10 || resp_rd_b !== 5'd0 || resp_data_b !== 32'd0) begin
            bad++; $display("FAIL lat3_sw_resp v/wr=%b rd=%0d data=%h exp=10 0 0",
                            {resp_valid_b, mem_wr_b}, resp_rd_b, resp_data_b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_req(1'b0, SZ_W, 1'b0, 32'h8000_0020, 32'h0, 5'd4);
        req_valid_a = 1'b1; resp_ready = 1'b1; mem_rdata_a = GARB;
        @(negedge clk);
        req_valid_a = 1'b0;
        total++;
        if (mem_rd_a !== 1'b1) begin
            bad++; $display("FAIL rstmid_issue rd=%b exp=1", mem_rd_a);
        end
        @(negedge clk);
        rstn_in = 1'b0;
        mem_rdata_a = 32'hFFFF_FFFF;
        #1;
        total++;
        if ({req_ready_a, mem_rd_a, resp_valid_a} !== 3'b100 || resp_data_a !== 32'd0) begin
            bad++; $display("FAIL rstmid_async ready/rd/v=%b data=%h exp=100 0",
                            {req_ready_a, mem_rd_a, resp_valid_a}, resp_data_a);
        end
        @(negedge clk);
        rstn_in = 1'b1;
        mem_rdata_a = GARB;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({req_ready_a, mem_rd_a, resp_valid_a} !== 3'b100) begin
                bad++; $display("FAIL rstmid_idle%0d ready/rd/v=%b exp=100", i, {req_ready_a, mem_rd_a, resp_valid_a});
            end
        end
        do_load_a(32'h8000_0024, SZ_W, 1'b0, 5'd11, 32'h600D_CAFE, 32'h600D_CAFE, "lw_after_rst");
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_stall_lat3();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
